rst_seq_ctrl: RTL and testbench
===============================

// Module: rst_seq_ctrl
// PURPOSE
//  Reset sequencer for the clocked register domains (clk_*_reset family). Holds N downstream
//  domains in reset, then releases them one at a time in ascending index order with a fixed gap.
//  Sequence starts at power-on (rst) or on a software request naming a subset of domains.
//  Sits between the top-level reset pin and the per-domain rst inputs of datapath blocks.
// PARAMETERS
//  N_DOM        4   number of controlled reset domains (>=1)
//  HOLD_CYC     8   cycles all selected domains stay in reset before the first release (>=1)
//  STAGGER_CYC  2   cycles between consecutive selected-domain releases (>=1)
//  CNT_W        derived localparam = $clog2(max(HOLD_CYC,STAGGER_CYC)+1)
// PORTS
//  clk       in   1      system clock, all logic on posedge
//  rst       in   1      synchronous, active-high reset
//  sw_req    in   1      1-cycle software reset request, sampled in IDLE only
//  sw_mask   in   N_DOM  domains to reset with sw_req (bit i = domain i)
//  rst_out   out  N_DOM  per-domain reset, active-high, registered
//  busy      out  1      1 while a sequence is in progress
//  done      out  1      1-cycle pulse on the edge the last selected domain is released
//  req_drop  out  1      1-cycle pulse when sw_req is ignored (busy, or sw_mask==0)
// BEHAVIOUR
//  - rst=1 at an edge: rst_out=all ones, busy=1, done=0, req_drop=0, mask=all ones,
//    state=HOLD, counter cleared. rst held high keeps this state; count starts on first edge with rst=0.
//  - States: IDLE, HOLD, RELEASE.
//  - HOLD: counts HOLD_CYC edges with rst=0; on edge HOLD_CYC, lowest set mask bit's rst_out
//    deasserts, state -> RELEASE (or IDLE if it was the only set bit).
//  - RELEASE: every STAGGER_CYC edges deassert next-higher set mask bit; unselected indices are
//    skipped with no delay (priority-encode next set bit above current index).
//  - Last selected bit deasserts: same edge done=1 (one cycle), busy=0, state -> IDLE.
//  - IDLE: sw_req=1 & sw_mask!=0 -> next edge latch mask, rst_out |= mask, busy=1, HOLD, counter 0.
//    Unselected domains are never touched (stay 0). sw_req=1 & sw_mask==0 -> req_drop pulse.
//  - sw_req while busy: ignored, req_drop pulse, no queueing; sw_mask changes mid-sequence ignored.
//  - rst mid-sequence: abort, full restart (all domains asserted, mask all ones).
//  - Power-on latency with defaults: rst_out=1111 for 8 edges, then 1110, 1100 (+2), 1000 (+4),
//    0000 with done (+6): 14 edges from first rst=0 edge to done.
//  - Outputs are registered only; no combinational path from inputs to rst_out/busy/done.
// STRUCTURE
//  - Shared include rst_seq_defs.vh: state encodings (IDLE/HOLD/RELEASE), default
//    HOLD_CYC/STAGGER_CYC values, reused by other sequencers/testbenches.
//  - One sub-module: rst_seq_cnt - loadable down-counter (CNT_W), sync clear, zero flag;
//    used for both HOLD and STAGGER timing.
//  - Top: FSM, mask register, current-index register, next-set-bit priority encoder.
// TESTING
//  1 Power-on: rst=1 3 cycles then 0 -> rst_out 1111x8, 1110, 1100, 1000, 0000; done 1 cycle at edge 14, busy falls same edge.
//  2 SW subset: IDLE, sw_req=1 sw_mask=0101 -> rst_out 0101 next edge; after 8 edges 0100; 2 edges later 0000 + done.
//  3 Single domain: sw_mask=1000 -> 1000 for 8 edges, then 0000 + done with no stagger delay.
//  4 Busy/zero-mask drops: sw_req during HOLD, and sw_req with sw_mask=0000 in IDLE -> req_drop pulse, rst_out/timing unchanged.
//  5 Reset mid-op: rst=1 while rst_out=1100 -> next edge rst_out=1111, busy=1; full 14-edge sequence replays after rst=0.
//  6 Params: N_DOM=2 HOLD_CYC=1 STAGGER_CYC=1 -> after rst: 11, 10, 00 + done on edges 1 and 2.

Source files
------------

// File: rtl/rst_seq_ctrl_pkg.sv
// Shared definitions for the reset sequencer family: state encodings, default timing
// parameters and the counter width helper.
package rst_seq_ctrl_pkg;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t ST_IDLE    = 2'd0;
  localparam seq_state_t ST_HOLD    = 2'd1;
  localparam seq_state_t ST_RELEASE = 2'd2;

  localparam int DEF_N_DOM       = 4;
  localparam int DEF_HOLD_CYC    = 8;
  localparam int DEF_STAGGER_CYC = 2;

  // Counter must hold the larger of the two timing values.
  function automatic int cnt_width(input int hold_cyc, input int stagger_cyc);
    int max_cyc;
    max_cyc = (hold_cyc > stagger_cyc) ? hold_cyc : stagger_cyc;
    return $clog2(max_cyc + 1);
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Software request / per-domain reset bundle between the reset sequencer and its users.
interface rst_seq_ctrl_if #(
  parameter int N_DOM = 4
);
  logic             sw_req;
  logic [N_DOM-1:0] sw_mask;
  logic [N_DOM-1:0] rst_out;
  logic             busy;
  logic             done;
  logic             req_drop;

  modport master (
    output sw_req, sw_mask,
    input  rst_out, busy, done, req_drop
  );

  modport slave (
    input  sw_req, sw_mask,
    output rst_out, busy, done, req_drop
  );
endinterface

// File: rtl/rst_seq_cnt.sv
// Loadable down-counter shared by the HOLD and STAGGER intervals of the reset sequencer.
module rst_seq_cnt
  import rst_seq_ctrl_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  // Load wins over clear so a reset can restart the hold interval in one edge.
  always_ff @(posedge clk) begin
    if (load_i) begin
      cnt_q <= load_val_i;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds the selected domains in reset, then releases them one by one in
// ascending index order with a fixed gap. Started by rst or by a software request.
module rst_seq_ctrl
  import rst_seq_ctrl_pkg::*;
#(
  parameter int N_DOM       = DEF_N_DOM,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int STAGGER_CYC = DEF_STAGGER_CYC
) (
  input  logic         clk,
  input  logic         rst,
  rst_seq_ctrl_if.slave bus
);

  localparam int CNT_W = cnt_width(HOLD_CYC, STAGGER_CYC);
  localparam int IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;

  seq_state_t       state_q, state_d;
  logic [N_DOM-1:0] mask_q, mask_d;
  logic [N_DOM-1:0] rst_out_q, rst_out_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             drop_q, drop_d;

  logic             cnt_load, cnt_clr, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;

  logic [N_DOM-1:0] elig;
  logic [N_DOM-1:0] remaining;
  logic [IDX_W-1:0] nxt_idx;
  logic             nxt_last;

  // Candidates for the next release: every selected bit while holding, afterwards only
  // selected bits above the one most recently released.
  for (genvar gi = 0; gi < N_DOM; gi++) begin : g_elig
    localparam logic [IDX_W:0] GI_IDX = (IDX_W+1)'(gi);
    assign elig[gi] = mask_q[gi] && ((state_q == ST_HOLD) || (GI_IDX > {1'b0, idx_q}));
  end

  always_comb begin
    nxt_idx = '0;
    for (int i = N_DOM - 1; i >= 0; i--) begin
      if (elig[i]) begin
        nxt_idx = IDX_W'(i);
      end
    end
  end

  assign remaining = elig & ~(N_DOM'(1) << nxt_idx);
  assign nxt_last  = (remaining == '0);

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    rst_out_d    = rst_out_q;
    idx_d        = idx_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    drop_d       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = CNT_W'(HOLD_CYC - 1);
    cnt_clr      = 1'b0;
    cnt_dec      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.sw_req) begin
          if (bus.sw_mask != '0) begin
            mask_d    = bus.sw_mask;
            rst_out_d = rst_out_q | bus.sw_mask;
            busy_d    = 1'b1;
            state_d   = ST_HOLD;
            cnt_load  = 1'b1;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      ST_HOLD, ST_RELEASE: begin
        drop_d = bus.sw_req;
        if (cnt_zero) begin
          rst_out_d[nxt_idx] = 1'b0;
          idx_d              = nxt_idx;
          if (nxt_last) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            state_d      = ST_RELEASE;
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(STAGGER_CYC - 1);
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_HOLD;
      mask_q    <= '1;
      rst_out_q <= '1;
      idx_q     <= '0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      rst_out_q <= rst_out_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
    end
  end

  // Reset reloads the hold interval so the first rst=0 edge counts as hold edge 1.
  rst_seq_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk        (clk),
    .clr_i      (cnt_clr & ~rst),
    .load_i     (cnt_load | rst),
    .load_val_i (rst ? CNT_W'(HOLD_CYC - 1) : cnt_load_val),
    .dec_i      (cnt_dec & ~rst),
    .zero_o     (cnt_zero)
  );

  assign bus.rst_out  = rst_out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.req_drop = drop_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: directed scenarios plus random traffic compared
// against a release-schedule model (release k of a sequence lands HOLD + k*STAGGER edges in).
module tb_rst_seq_ctrl;

  localparam int H = 8;
  localparam int S = 2;

  logic clk;
  logic rst;
  logic rst2;

  rst_seq_ctrl_if #(.N_DOM(4)) bus ();
  rst_seq_ctrl_if #(.N_DOM(2)) bus2 ();

  rst_seq_ctrl #(.N_DOM(4), .HOLD_CYC(H), .STAGGER_CYC(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rst_seq_ctrl #(.N_DOM(2), .HOLD_CYC(1), .STAGGER_CYC(1)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [3:0] m_mask, m_out;
  logic       m_busy, m_done, m_drop;
  int         m_t;

  task automatic model_edge(input logic r, input logic req, input logic [3:0] msk);
    int k;
    m_done = 1'b0;
    m_drop = 1'b0;
    if (r) begin
      m_out = 4'hF; m_mask = 4'hF; m_busy = 1'b1; m_t = 0;
    end else if (!m_busy) begin
      if (req && msk != 4'h0) begin
        m_mask = msk; m_out = m_out | msk; m_busy = 1'b1; m_t = 0;
      end else if (req) begin
        m_drop = 1'b1;
      end
    end else begin
      if (req) m_drop = 1'b1;
      m_t++;
      k = 0;
      for (int i = 0; i < 4; i++) begin
        if (m_mask[i]) begin
          if (m_t == H + k * S) m_out[i] = 1'b0;
          k++;
        end
      end
      if (m_t == H + (k - 1) * S) begin
        m_done = 1'b1;
        m_busy = 1'b0;
      end
    end
  endtask

  // Drive inputs, advance one edge, update the model, settle 1 ns past the edge.
  task automatic step(input logic r, input logic req, input logic [3:0] msk);
    rst         = r;
    bus.sw_req  = req;
    bus.sw_mask = msk;
    @(posedge clk);
    model_edge(r, req, msk);
    #1;
  endtask

  task automatic test_reset();
    int done_edge;
    done_edge = -1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 4'h0);
      n_cmp++;
      if ({bus.rst_out, bus.busy, bus.done, bus.req_drop} !== 7'b1111_1_0_0) begin
        n_bad++;
        $display("FAIL reset_state cyc%0d: got out=%b busy=%b done=%b drop=%b, want out=1111 busy=1 done=0 drop=0",
                 i, bus.rst_out, bus.busy, bus.done, bus.req_drop);
      end
    end
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b0, 4'h0);
      if (bus.done === 1'b1) done_edge = i;
      n_cmp++;
      if ({bus.rst_out, bus.busy, bus.done, bus.req_drop} !== {m_out, m_busy, m_done, m_drop}) begin
        n_bad++;
        $display("FAIL power_on edge%0d: got out=%b busy=%b done=%b drop=%b, want out=%b busy=%b done=%b drop=%b",
                 i, bus.rst_out, bus.busy, bus.done, bus.req_drop, m_out, m_busy, m_done, m_drop);
      end
    end
    n_cmp++;
    if (done_edge !== 14) begin
      n_bad++;
      $display("FAIL power_on_latency: got done at edge %0d, want 14", done_edge);
    end
    $display("power-on sequence: done at edge %0d", done_edge);
  endtask

  task automatic test_sw_seq(input string name, input logic [3:0] msk, input int n_edges);
    step(1'b0, 1'b1, msk);
    n_cmp++;
    if (bus.rst_out !== msk || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_start: got out=%b busy=%b, want out=%b busy=1", name, bus.rst_out, bus.busy, msk);
    end
    for (int i = 1; i <= n_edges; i++) begin
      step(1'b0, 1'b0, 4'h0);
      n_cmp++;
      if ({bus.rst_out, bus.busy, bus.done, bus.req_drop} !== {m_out, m_busy, m_done, m_drop}) begin
        n_bad++;
        $display("FAIL %s edge%0d: got out=%b busy=%b done=%b drop=%b, want out=%b busy=%b done=%b drop=%b",
                 name, i, bus.rst_out, bus.busy, bus.done, bus.req_drop, m_out, m_busy, m_done, m_drop);
      end
    end
    $display("sw request %s mask=%b complete", name, msk);
  endtask

  task automatic test_drops();
    logic [3:0] req_v;
    logic [3:0] msk_v;
    step(1'b0, 1'b1, 4'b0011);
    for (int i = 1; i <= 13; i++) begin
      // Request during HOLD at edge 3, then a zero-mask request in IDLE after the sequence.
      req_v = (i == 3 || i == 12) ? 4'h1 : 4'h0;
      msk_v = (i == 3) ? 4'b1111 : 4'b0000;
      step(1'b0, req_v[0], msk_v);
      n_cmp++;
      if ({bus.rst_out, bus.busy, bus.done, bus.req_drop} !== {m_out, m_busy, m_done, m_drop}) begin
        n_bad++;
        $display("FAIL drops edge%0d: got out=%b busy=%b done=%b drop=%b, want out=%b busy=%b done=%b drop=%b",
                 i, bus.rst_out, bus.busy, bus.done, bus.req_drop, m_out, m_busy, m_done, m_drop);
      end
    end
    $display("drop requests: busy and zero-mask issued");
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b1, 4'hF);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 4'h0);
    n_cmp++;
    if (bus.rst_out !== 4'b1100) begin
      n_bad++;
      $display("FAIL reset_mid_pre: got out=%b, want out=1100", bus.rst_out);
    end
    step(1'b1, 1'b0, 4'h0);
    for (int i = 0; i <= 15; i++) begin
      n_cmp++;
      if ({bus.rst_out, bus.busy, bus.done, bus.req_drop} !== {m_out, m_busy, m_done, m_drop}) begin
        n_bad++;
        $display("FAIL reset_mid edge%0d: got out=%b busy=%b done=%b drop=%b, want out=%b busy=%b done=%b drop=%b",
                 i, bus.rst_out, bus.busy, bus.done, bus.req_drop, m_out, m_busy, m_done, m_drop);
      end
      step(1'b0, 1'b0, 4'h0);
    end
    $display("reset mid-sequence: replay checked");
  endtask

  task automatic test_random();
    logic       r, req;
    logic [3:0] msk;
    int         n_req;
    n_req = 0;
    for (int i = 0; i < 800; i++) begin
      r   = ($urandom_range(0, 149) == 0);
      req = ($urandom_range(0, 5) == 0);
      msk = 4'($urandom);
      if (req) n_req++;
      step(r, req, msk);
      n_cmp++;
      if ({bus.rst_out, bus.busy, bus.done, bus.req_drop} !== {m_out, m_busy, m_done, m_drop}) begin
        n_bad++;
        $display("FAIL random cyc%0d (r=%b req=%b msk=%b): got out=%b busy=%b done=%b drop=%b, want out=%b busy=%b done=%b drop=%b",
                 i, r, req, msk, bus.rst_out, bus.busy, bus.done, bus.req_drop, m_out, m_busy, m_done, m_drop);
      end
    end
    $display("random traffic: %0d requests issued", n_req);
  endtask

  task automatic test_params();
    logic [3:0] exp_v [4];
    exp_v[0] = 4'b11_1_0;
    exp_v[1] = 4'b10_1_0;
    exp_v[2] = 4'b00_0_1;
    exp_v[3] = 4'b00_0_0;
    rst2 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({bus2.rst_out, bus2.busy, bus2.done} !== exp_v[i]) begin
        n_bad++;
        $display("FAIL params edge%0d: got out=%b busy=%b done=%b, want {out,busy,done}=%b",
                 i, bus2.rst_out, bus2.busy, bus2.done, exp_v[i]);
      end
      rst2 = 1'b0;
      @(posedge clk); #1;
    end
    $display("small-parameter instance sequence checked");
  endtask

  initial begin
    rst          = 1'b1;
    rst2         = 1'b1;
    bus.sw_req   = 1'b0;
    bus.sw_mask  = '0;
    bus2.sw_req  = 1'b0;
    bus2.sw_mask = '0;
    m_mask = 4'hF; m_out = 4'hF; m_busy = 1'b1; m_done = 1'b0; m_drop = 1'b0; m_t = 0;

    test_reset();
    test_sw_seq("subset", 4'b0101, 12);
    test_sw_seq("single", 4'b1000, 10);
    test_sw_seq("upper3", 4'b1110, 16);
    test_drops();
    test_reset_mid();
    test_random();
    test_params();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
